// File: rtl/volume_ramp.sv
// ============================================================================
// Module  : volume_ramp
// Brief   : Per-sample ramped output gain with soft mute and optional clamp.
//           Define VOLUME_RAMP_SAT_EN for a saturating output, else it wraps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module volume_ramp #(
    parameter int GAIN_W = 8,
    parameter int STEP   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [23:0]       in_data,
    input  logic              wren,
    input  logic [GAIN_W-1:0] target,
    input  logic              mute,
    output logic [23:0]       out_data,
    output logic              out_valid,
    output logic              muted
);

    localparam int c_PW = 24 + GAIN_W + 1;
    localparam logic [GAIN_W:0]            c_STEP = (GAIN_W + 1)'(STEP);
    localparam logic signed [c_PW-1:0]     c_MAX  = c_PW'(8388607);
    localparam logic signed [c_PW-1:0]     c_MIN  = -c_MAX - c_PW'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FADE  = 2'd1,
        ST_MUTED = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GAIN_W-1:0]   r_gain;
    logic [GAIN_W-1:0]   w_gain_nxt;
    logic [GAIN_W-1:0]   w_goal;
    logic [GAIN_W:0]     w_dist;
    logic [23:0]         r_out;
    logic                r_valid;

    logic signed [c_PW-1:0] w_a;
    logic signed [c_PW-1:0] w_b;
    logic signed [c_PW-1:0] w_prod;
    logic signed [c_PW-1:0] w_scaled;
    logic [23:0]            w_sat;

    assign w_goal = mute ? '0 : target;

    // Gain path: snap to the goal once within one step so the ramp never overshoots
    always_comb begin
        w_gain_nxt = r_gain;
        w_dist     = '0;
        if (wren) begin
            if (w_goal >= r_gain) begin
                w_dist = {1'b0, w_goal} - {1'b0, r_gain};
                if (w_dist <= c_STEP)
                    w_gain_nxt = w_goal;
                else
                    w_gain_nxt = r_gain + c_STEP[GAIN_W-1:0];
            end else begin
                w_dist = {1'b0, r_gain} - {1'b0, w_goal};
                if (w_dist <= c_STEP)
                    w_gain_nxt = w_goal;
                else
                    w_gain_nxt = r_gain - c_STEP[GAIN_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (wren) begin
            case (r_state)
                ST_RUN:   if (mute) w_state_nxt = ST_FADE;
                ST_FADE: begin
                    if (!mute)
                        w_state_nxt = ST_RUN;
                    else if (w_gain_nxt == '0)
                        w_state_nxt = ST_MUTED;
                end
                ST_MUTED: if (!mute) w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    // Gain is zero-extended so it multiplies as an unsigned quantity
    assign w_a      = {{(GAIN_W + 1){in_data[23]}}, in_data};
    assign w_b      = {{24{1'b0}}, 1'b0, r_gain};
    assign w_prod   = w_a * w_b;
    assign w_scaled = w_prod >>> (GAIN_W - 1);

`ifdef VOLUME_RAMP_SAT_EN
    always_comb begin
        if (w_scaled > c_MAX)
            w_sat = 24'h7F_FFFF;
        else if (w_scaled < c_MIN)
            w_sat = 24'h80_0000;
        else
            w_sat = w_scaled[23:0];
    end
`else
    logic w_unused_hi;
    assign w_unused_hi = ^{w_scaled[c_PW-1:24]};
    assign w_sat       = w_scaled[23:0];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gain  <= '0;
            r_state <= ST_RUN;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_gain  <= w_gain_nxt;
            r_state <= w_state_nxt;
            r_valid <= wren;
            if (wren && (r_state != ST_MUTED))
                r_out <= w_sat;
            else
                r_out <= '0;
        end
    end

    assign out_data  = r_out;
    assign out_valid = r_valid;
    assign muted     = (r_state == ST_MUTED);

endmodule

`default_nettype wire

// File: tb/tb_volume_ramp.sv
// ============================================================================
// Module  : tb_volume_ramp
// Brief   : Scoreboard bench for volume_ramp, two instances (STEP=1 and STEP=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_volume_ramp;

    localparam int GW = 8;
    localparam int M_RUN = 0, M_FADE = 1, M_MUTED = 2;

    typedef struct packed {
        logic [23:0] d;
        logic        m;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] in_data = '0;
    logic        wren = 1'b0;
    logic [7:0]  target = '0;
    logic        mute = 1'b0;
    logic [23:0] od0, od1;
    logic        ov0, ov1, mu0, mu1;

    int   n_vec = 0;
    int   n_err = 0;
    bit   done  = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    int   mgain[2];
    int   mstate[2];
    int   stp[2] = '{1, 4};

    always #5 clk = ~clk;

    volume_ramp #(.GAIN_W(GW), .STEP(1)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .wren(wren),
        .target(target), .mute(mute),
        .out_data(od0), .out_valid(ov0), .muted(mu0)
    );

    volume_ramp #(.GAIN_W(GW), .STEP(4)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .wren(wren),
        .target(target), .mute(mute),
        .out_data(od1), .out_valid(ov1), .muted(mu1)
    );

    // Reference: scale by the gain held before this sample, then ramp and step the mode
    function automatic exp_t model(int i, int x, int tg, bit mu);
        exp_t   e;
        longint s;
        int     g;
        int     d;
        s = (longint'(x) * longint'(mgain[i])) >>> (GW - 1);
`ifdef VOLUME_RAMP_SAT_EN
        if (s > 64'sd8388607)       s = 64'sd8388607;
        else if (s < -64'sd8388608) s = -64'sd8388608;
`endif
        e.d = s[23:0];
        if (mstate[i] == M_MUTED) e.d = '0;
        g = mu ? 0 : tg;
        d = g - mgain[i];
        if (d > stp[i])       mgain[i] = mgain[i] + stp[i];
        else if (d < -stp[i]) mgain[i] = mgain[i] - stp[i];
        else                  mgain[i] = g;
        if (mstate[i] == M_RUN) begin
            if (mu) mstate[i] = M_FADE;
        end else if (mstate[i] == M_FADE) begin
            if (!mu)               mstate[i] = M_RUN;
            else if (mgain[i] == 0) mstate[i] = M_MUTED;
        end else begin
            if (!mu) mstate[i] = M_RUN;
        end
        e.m = (mstate[i] == M_MUTED);
        return e;
    endfunction

    task automatic drive(bit rn, bit wr, int x, int tg, bit mu);
        @(negedge clk);
        reset   = rn;
        wren    = wr;
        in_data = x[23:0];
        target  = tg[7:0];
        mute    = mu;
        if (!rn) begin
            for (int i = 0; i < 2; i++) begin
                mgain[i]  = 0;
                mstate[i] = M_RUN;
            end
        end else if (wr) begin
            q0.push_back(model(0, x, tg, mu));
            q1.push_back(model(1, x, tg, mu));
        end
    endtask

    task automatic check(int i, logic v, logic [23:0] d, logic m);
        exp_t e;
        n_vec++;
        if (v) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                n_err++;
                $display("FAIL unexpected_valid inst%0d: got valid with data %0d, expected no output",
                         i, $signed(d));
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                if (d !== e.d || m !== e.m) begin
                    n_err++;
                    $display("FAIL sample inst%0d @%0t: data %0d muted %0b, expected data %0d muted %0b",
                             i, $time, $signed(d), m, $signed(e.d), e.m);
                end
            end
        end else if (d !== 24'd0 || m !== (mstate[i] == M_MUTED)) begin
            n_err++;
            $display("FAIL idle inst%0d @%0t: data %0d muted %0b, expected data 0 muted %0b",
                     i, $time, $signed(d), m, (mstate[i] == M_MUTED));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!done) begin
            check(0, ov0, od0, mu0);
            check(1, ov1, od1, mu1);
        end
    end

    int tg_r;
    bit mu_r;

    initial begin
        for (int i = 0; i < 2; i++) begin
            mgain[i]  = 0;
            mstate[i] = M_RUN;
        end
        // Reset with a coincident sample that must be dropped
        drive(0, 1, 1234, 128, 0);
        drive(0, 1, 1234, 128, 0);
        // Soft start from silence to unity
        for (int k = 0; k < 200; k++) drive(1, 1, 1000, 128, 0);
        // Unity pass-through, then idle gaps
        drive(1, 1, -5000, 128, 0);
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 128, 0);
        // Settle at 255 and drive both rails
        for (int k = 0; k < 140; k++) drive(1, 1, 77, 255, 0);
        drive(1, 1, 8000000, 255, 0);
        drive(1, 0, 0, 255, 0);
        drive(1, 1, -8000000, 255, 0);
        drive(1, 1, 8388607, 255, 0);
        // Back to unity, full mute cycle
        for (int k = 0; k < 140; k++) drive(1, 1, 3000, 128, 0);
        for (int k = 0; k < 140; k++) drive(1, 1, 3000, 128, 1);
        for (int k = 0; k < 140; k++) drive(1, 1, -3000, 128, 0);
        // Reset in the middle of a fade
        for (int k = 0; k < 10; k++) drive(1, 1, 5000, 128, 1);
        drive(0, 1, 5000, 128, 1);
        for (int k = 0; k < 20; k++) drive(1, 1, 5000, 128, 0);
        // Idle hold: target moves with no samples, gain must not
        for (int k = 0; k < 120; k++) drive(1, 1, 100, 128, 0);
        for (int k = 0; k < 50; k++) drive(1, 0, 0, 64, 0);
        drive(1, 1, 6400, 64, 0);
        // Randomised traffic
        tg_r = 128;
        mu_r = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) tg_r = int'($urandom_range(0, 255));
            if ($urandom_range(0, 39) == 0) mu_r = ~mu_r;
            drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) < 7),
                  int'($urandom_range(0, 16777215)) - 8388608, tg_r, mu_r);
        end
        for (int k = 0; k < 4; k++) drive(1, 0, 0, tg_r, mu_r);
        @(negedge clk);
        done = 1'b1;
        n_vec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d outputs still pending, expected 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
